// File: rtl/pe_conv_mac_buffer_ctrl_conv1.sv
// Write/read sequencer for the conv1 MAC output buffer: collects NG result groups per
// pixel, then holds the complete pixel for a valid/ready handoff and tracks frame position.
module pe_conv_mac_buffer_ctrl_conv1 #(
  parameter int pOUT_CHANNEL     = 32,
  parameter int pOUTPUT_PARALLEL = 32,
  parameter int pOUT_PIXELS      = 12544,
  localparam int NG     = pOUT_CHANNEL / pOUTPUT_PARALLEL,
  localparam int pIDX_W = (NG > 1) ? $clog2(NG) : 1,
  localparam int CNT_W  = $clog2(pOUT_PIXELS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mac_valid,
  output logic              mac_ready,
  output logic              buf_wr_en,
  output logic [pIDX_W-1:0] buf_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done,
  output logic [CNT_W-1:0]  pixel_cnt
);

  typedef enum logic {FILL, FULL} state_t;

  localparam logic [pIDX_W-1:0] LAST_GRP = pIDX_W'(NG - 1);
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(pOUT_PIXELS - 1);

  state_t             r_state;
  logic [pIDX_W-1:0]  r_grp;
  logic [CNT_W-1:0]   r_pix;
  logic               r_is_last;
  logic               r_frame_done;
  logic [CNT_W-1:0]   w_pix_next;

  // In FULL the group counter is already back at 0, so buf_idx needs no state mux.
  assign mac_ready  = (r_state == FILL) | out_ready;
  assign buf_wr_en  = mac_valid & mac_ready;
  assign buf_idx    = r_grp;
  assign out_valid  = (r_state == FULL);
  assign out_last   = (r_state == FULL) & r_is_last;
  assign frame_done = r_frame_done;
  assign pixel_cnt  = r_pix;

  assign w_pix_next = r_is_last ? '0 : r_pix + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state      <= FILL;
      r_grp        <= '0;
      r_pix        <= '0;
      r_is_last    <= (pOUT_PIXELS == 1);
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (mac_valid) begin
            if (r_grp == LAST_GRP) begin
              r_grp   <= '0;
              r_state <= FULL;
            end else begin
              r_grp <= r_grp + pIDX_W'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            r_frame_done <= r_is_last;
            r_pix        <= w_pix_next;
            r_is_last    <= (w_pix_next == LAST_PIX);
            // A group arriving with the handoff is slot 0 of the next pixel.
            if (mac_valid && NG == 1) begin
              r_state <= FULL;
            end else if (mac_valid) begin
              r_state <= FILL;
              r_grp   <= pIDX_W'(1);
            end else begin
              r_state <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
